// File: rtl/regfile_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port register array among NREQ requesters.
// Define ARB_FIXED_PRIO_EN to give requester 0 absolute priority over a round-robin of the rest.
module regfile_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic [DW-1:0]        rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] last;
    logic [IW-1:0] win;
    logic          win_vld;
    logic          win_upd;
    logic          we_lat;
    logic [DW-1:0] rdata_q;

    // Position k steps after base within the rotating group [lo, NREQ-1].
    function automatic logic [IW-1:0] rr_pos(input logic [IW-1:0] base, input int k, input int lo);
        int span;
        int pos;
        span = NREQ - lo;
        pos  = lo + ((int'(base) - lo + k) % span);
        return pos[IW-1:0];
    endfunction

    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        win_upd = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        if (req[0]) begin
            win_vld = 1'b1;
        end else begin
            for (int k = 1; k < NREQ; k++) begin
                if (!win_vld && req[rr_pos(last, k, 1)]) begin
                    win     = rr_pos(last, k, 1);
                    win_vld = 1'b1;
                    win_upd = 1'b1;
                end
            end
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_vld && req[rr_pos(last, k, 0)]) begin
                win     = rr_pos(last, k, 0);
                win_vld = 1'b1;
                win_upd = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= IW'(NREQ - 1);
            gnt       <= '0;
            ack       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            we_lat    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt       <= NREQ'(1) << win;
                        we_lat    <= req_we[win];
                        mem_en    <= 1'b1;
                        mem_we    <= req_we[win];
                        mem_addr  <= req_addr[int'(win)*AW +: AW];
                        mem_wdata <= req_wdata[int'(win)*DW +: DW];
                        if (win_upd) begin
                            last <= win;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    ack    <= gnt;
                    state  <= RESP;
                end
                RESP: begin
                    if (!we_lat) begin
                        rdata_q <= mem_rdata;
                    end
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Array data arrives during RESP, so it is forwarded alongside ack and captured for later.
    assign rdata = (state == RESP && !we_lat) ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_regfile_rr_arbiter.sv
// Bench for regfile_rr_arbiter: directed steps plus random traffic against a transaction-level model.
module tb_regfile_rr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      ack;
    logic [DW-1:0]        rdata;
    logic                 mem_en;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata;

    logic [DW-1:0] arr [32];
    logic          mem_clr;
    logic [DW-1:0] ref_mem [32];
    logic [DW-1:0] last_rdata;
    int            model_last;
    int            n_cmp = 0;
    int            n_err = 0;
    int            w;

    regfile_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .rdata(rdata), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port array macro: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) arr[i] <= '0;
        end else if (mem_en) begin
            if (mem_we) arr[mem_addr] <= mem_wdata;
            else        mem_rdata <= arr[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]                = 1'b1;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // Reference arbitration: first pending requester after the last winner, cyclically.
    function automatic int pick(input logic [NREQ-1:0] p, input int lst);
`ifdef ARB_FIXED_PRIO_EN
        if (p[0]) return 0;
        for (int k = 1; k < NREQ; k++) begin
            int i;
            i = 1 + (lst - 1 + k) % (NREQ - 1);
            if (p[i]) return i;
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (lst + k) % NREQ;
            if (p[i]) return i;
        end
`endif
        return -1;
    endfunction

    // Called at a negedge with the DUT idle; walks one full grant/issue/response/idle transfer.
    task automatic do_round(input int wexp, input logic keep);
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        we = req_we[wexp];
        a  = req_addr[wexp*AW +: AW];
        d  = req_wdata[wexp*DW +: DW];
        @(negedge clk);
        check("gnt_issue", 32'(gnt), 32'(1) << wexp);
        check("mem_en_issue", 32'(mem_en), 32'd1);
        check("mem_we_issue", 32'(mem_we), 32'(we));
        check("mem_addr_issue", 32'(mem_addr), 32'(a));
        if (we) check("mem_wdata_issue", 32'(mem_wdata), 32'(d));
        check("ack_issue", 32'(ack), 32'd0);
        req_addr[wexp*AW +: AW]  = ~a;
        req_wdata[wexp*DW +: DW] = ~d;
        @(negedge clk);
        check("ack_resp", 32'(ack), 32'(1) << wexp);
        check("gnt_resp", 32'(gnt), 32'(1) << wexp);
        check("mem_en_resp", 32'(mem_en), 32'd0);
        if (we) begin
            check("rdata_hold_wr", 32'(rdata), 32'(last_rdata));
            ref_mem[a] = d;
        end else begin
            check("rdata_read", 32'(rdata), 32'(ref_mem[a]));
            last_rdata = ref_mem[a];
        end
        if (!keep) req[wexp] = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        if (wexp != 0) model_last = wexp;
`else
        model_last = wexp;
`endif
        @(negedge clk);
        check("ack_idle", 32'(ack), 32'd0);
        check("gnt_idle", 32'(gnt), 32'd0);
        check("mem_en_idle", 32'(mem_en), 32'd0);
        check("rdata_idle", 32'(rdata), 32'(last_rdata));
    endtask

    initial begin
        rst_n = 1'b0; mem_clr = 1'b1;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        model_last = NREQ - 1; last_rdata = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;

        // Reset state
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        mem_clr = 1'b0;
        rst_n   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_mem_en", 32'(mem_en), 32'd0);
            check("idle_gnt", 32'(gnt), 32'd0);
        end

        // Write then read back through requester 2
        set_cmd(2, 1'b1, 5'd7, 8'hA5);
        do_round(2, 1'b0);
        set_cmd(2, 1'b0, 5'd7, 8'h00);
        do_round(2, 1'b0);
        check("rdata_a5", 32'(rdata), 32'hA5);

`ifndef ARB_FIXED_PRIO_EN
        // Fairness with all requesters held
        set_cmd(3, 1'b0, 5'd1, 8'h00);
        do_round(3, 1'b0);
        set_cmd(0, 1'b1, 5'd10, 8'h11);
        set_cmd(1, 1'b1, 5'd11, 8'h22);
        set_cmd(2, 1'b1, 5'd12, 8'h33);
        set_cmd(3, 1'b0, 5'd10, 8'h00);
        do_round(0, 1'b1);
        do_round(1, 1'b1);
        do_round(2, 1'b1);
        do_round(3, 1'b1);
        do_round(0, 1'b0);
        req = '0;

        // Wrap from last=3 to requester 0, then back to 3
        set_cmd(3, 1'b1, 5'd20, 8'h5A);
        do_round(3, 1'b1);
        set_cmd(0, 1'b0, 5'd20, 8'h00);
        do_round(0, 1'b0);
        do_round(3, 1'b0);
`endif

        // Random traffic
        for (int r = 0; r < 60; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1)
                    set_cmd(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom_range(0, 255)));
            end
            if (req == '0)
                set_cmd(int'($urandom_range(0, NREQ - 1)), 1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, 31)), DW'($urandom_range(0, 255)));
            w = pick(req, model_last);
            do_round(w, $urandom_range(0, 3) == 0);
        end
        req = '0;

        // Reset during ISSUE aborts the transfer
        set_cmd(1, 1'b0, 5'd3, 8'h00);
        @(negedge clk);
        check("abort_pre_en", 32'(mem_en), 32'd1);
        req = '0;
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_en", 32'(mem_en), 32'd0);
        check("abort_gnt", 32'(gnt), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        check("abort_ack_hold", 32'(ack), 32'd0);
        rst_n = 1'b1;
        model_last = NREQ - 1;
        last_rdata = '0;
        set_cmd(0, 1'b0, 5'd7, 8'h00);
        set_cmd(1, 1'b0, 5'd8, 8'h00);
        set_cmd(2, 1'b0, 5'd9, 8'h00);
        set_cmd(3, 1'b0, 5'd6, 8'h00);
        do_round(0, 1'b0);
        req = '0;

`ifdef ARB_FIXED_PRIO_EN
        // Requester 0 dominates; the rest rotate once it drops
        set_cmd(0, 1'b0, 5'd1, 8'h00);
        set_cmd(1, 1'b0, 5'd2, 8'h00);
        set_cmd(2, 1'b0, 5'd3, 8'h00);
        do_round(0, 1'b1);
        do_round(0, 1'b1);
        do_round(0, 1'b1);
        req[0] = 1'b0;
        do_round(1, 1'b1);
        do_round(2, 1'b1);
        do_round(1, 1'b1);
        do_round(2, 1'b1);
        req = '0;
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
